// File: rtl/uma_priority_arbiter_pkg.sv
// Shared definitions for the UMA priority arbiter: mode encodings, counter width, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uma_priority_arbiter_pkg;

    localparam int ARB_MODE_FIXED = 0;
    localparam int ARB_MODE_RR    = 1;
    localparam int BUSY_W         = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } arb_state_e;

    // Saturating increment for the busy counter; sticks at all ones instead of wrapping.
    function automatic logic [BUSY_W-1:0] busy_sat_inc(input logic [BUSY_W-1:0] v);
        return (v == {BUSY_W{1'b1}}) ? v : v + BUSY_W'(1);
    endfunction

endpackage

// File: rtl/uma_priority_arbiter_priority_encoder_n.sv
// Lowest-set-index finder over an N-bit vector; idx is all ones when nothing is set.
// Latency: purely combinational.
// Backpressure: none.
module priority_encoder_n #(
    parameter int N = 16,
    localparam int IDXW = $clog2(N)
) (
    input  logic [N-1:0]    req_i,
    output logic [IDXW-1:0] idx_o,
    output logic            found_o
);

    // Scan from the top down so the lowest set bit is the last to write.
    always_comb begin
        idx_o   = '1;
        found_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o   = IDXW'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uma_priority_arbiter.sv
// Registered N-way arbiter for UMA masters; winner keeps a locked grant until it pulses release.
// Latency: request to grant_valid_o is one cycle; release re-arbitrates back-to-back with no idle cycle.
// Backpressure: enable_n_i high blocks new grants but never revokes the one already held.
module uma_priority_arbiter
    import uma_priority_arbiter_pkg::*;
#(
    parameter int N           = 16,
    parameter int ROUND_ROBIN = ARB_MODE_FIXED,
    localparam int IDXW       = $clog2(N)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              enable_n_i,
    input  logic [N-1:0]      req_i,
    input  logic              release_i,
    output logic              grant_valid_o,
    output logic [IDXW-1:0]   grant_idx_o,
    output logic [N-1:0]      grant_onehot_o,
    output logic [BUSY_W-1:0] busy_cycles_o
);

    localparam bit IS_RR = (ROUND_ROBIN == ARB_MODE_RR);

    arb_state_e        state_q;
    logic [IDXW-1:0]   rr_ptr_q;
    logic              grant_valid_q;
    logic [IDXW-1:0]   grant_idx_q;
    logic [N-1:0]      grant_onehot_q;
    logic [BUSY_W-1:0] busy_q;

    logic              rel_now;
    logic [IDXW-1:0]   ptr_next;
    logic [IDXW-1:0]   arb_ptr;
    logic [N-1:0]      req_mask;
    logic              win_found;
    logic [IDXW-1:0]   win_idx;
    logic              can_grant;

    // Pointer used for this cycle's arbitration: on a release the freshly advanced
    // pointer applies immediately so the releasing owner drops to lowest priority.
    // The wrap is explicit because N need not be a power of two.
    always_comb begin
        rel_now  = (state_q == ST_OWNED) && release_i;
        ptr_next = (grant_idx_q == IDXW'(N - 1)) ? '0 : grant_idx_q + IDXW'(1);
        arb_ptr  = '0;
        if (IS_RR) begin
            arb_ptr = rel_now ? ptr_next : rr_ptr_q;
        end
        req_mask = '0;
        for (int i = 0; i < N; i++) begin
            req_mask[i] = (IDXW'(i) >= arb_ptr);
        end
    end

    generate
        if (IS_RR) begin : g_rr
            logic [IDXW-1:0] m_idx, r_idx;
            logic            m_found, r_found;

            priority_encoder_n #(.N(N)) u_enc_masked (
                .req_i   (req_i & req_mask),
                .idx_o   (m_idx),
                .found_o (m_found)
            );

            priority_encoder_n #(.N(N)) u_enc_raw (
                .req_i   (req_i),
                .idx_o   (r_idx),
                .found_o (r_found)
            );

            // Prefer requesters at or above the pointer, otherwise wrap to the lowest overall.
            always_comb begin
                win_found = m_found | r_found;
                win_idx   = m_found ? m_idx : r_idx;
            end
        end else begin : g_fixed
            // In fixed mode the pointer is pinned at zero, so the mask is all ones.
            priority_encoder_n #(.N(N)) u_enc (
                .req_i   (req_i & req_mask),
                .idx_o   (win_idx),
                .found_o (win_found)
            );
        end
    endgenerate

    assign can_grant = !enable_n_i && win_found;

    // Two-state grant FSM with pointer, busy counter and all outputs registered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= ST_IDLE;
            rr_ptr_q       <= '0;
            grant_valid_q  <= 1'b0;
            grant_idx_q    <= '1;
            grant_onehot_q <= '0;
            busy_q         <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (can_grant) begin
                        state_q        <= ST_OWNED;
                        grant_valid_q  <= 1'b1;
                        grant_idx_q    <= win_idx;
                        grant_onehot_q <= N'(1) << win_idx;
                        busy_q         <= '0;
                    end
                end
                ST_OWNED: begin
                    if (release_i) begin
                        if (IS_RR) begin
                            rr_ptr_q <= ptr_next;
                        end
                        if (can_grant) begin
                            grant_idx_q    <= win_idx;
                            grant_onehot_q <= N'(1) << win_idx;
                            busy_q         <= '0;
                        end else begin
                            // Busy count is left as-is so software can read the last hold time.
                            state_q        <= ST_IDLE;
                            grant_valid_q  <= 1'b0;
                            grant_idx_q    <= '1;
                            grant_onehot_q <= '0;
                        end
                    end else begin
                        busy_q <= busy_sat_inc(busy_q);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // An unknown request vector while idle would make the winner undefined.
    a_req_known_idle: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (state_q == ST_IDLE) |-> !$isunknown(req_i)
    );

    assign grant_valid_o  = grant_valid_q;
    assign grant_idx_o    = grant_idx_q;
    assign grant_onehot_o = grant_onehot_q;
    assign busy_cycles_o  = busy_q;

endmodule

// File: tb/tb_uma_priority_arbiter.sv
// Directed bench: fixed N=16 (a_), round-robin N=16 (b_), round-robin N=12 (c_).
// Inputs change 1ns after the rising edge, outputs are sampled at that same point.
// Expected values are hand-derived constants.
module tb_uma_priority_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Instance A: fixed priority, N=16
    logic        a_rst_n = 1'b0, a_en_n = 1'b1, a_rel = 1'b0;
    logic [15:0] a_req = '0;
    logic        a_vld;
    logic [3:0]  a_idx;
    logic [15:0] a_oh, a_busy;

    // Instance B: round robin, N=16
    logic        b_rst_n = 1'b0, b_en_n = 1'b1, b_rel = 1'b0;
    logic [15:0] b_req = '0;
    logic        b_vld;
    logic [3:0]  b_idx;
    logic [15:0] b_oh, b_busy;

    // Instance C: round robin, N=12
    logic        c_rst_n = 1'b0, c_en_n = 1'b1, c_rel = 1'b0;
    logic [11:0] c_req = '0;
    logic        c_vld;
    logic [3:0]  c_idx;
    logic [11:0] c_oh;
    logic [15:0] c_busy;

    uma_priority_arbiter #(.N(16), .ROUND_ROBIN(0)) u_a (
        .clk_i(clk), .rst_ni(a_rst_n), .enable_n_i(a_en_n), .req_i(a_req), .release_i(a_rel),
        .grant_valid_o(a_vld), .grant_idx_o(a_idx), .grant_onehot_o(a_oh), .busy_cycles_o(a_busy)
    );

    uma_priority_arbiter #(.N(16), .ROUND_ROBIN(1)) u_b (
        .clk_i(clk), .rst_ni(b_rst_n), .enable_n_i(b_en_n), .req_i(b_req), .release_i(b_rel),
        .grant_valid_o(b_vld), .grant_idx_o(b_idx), .grant_onehot_o(b_oh), .busy_cycles_o(b_busy)
    );

    uma_priority_arbiter #(.N(12), .ROUND_ROBIN(1)) u_c (
        .clk_i(clk), .rst_ni(c_rst_n), .enable_n_i(c_en_n), .req_i(c_req), .release_i(c_rel),
        .grant_valid_o(c_vld), .grant_idx_o(c_idx), .grant_onehot_o(c_oh), .busy_cycles_o(c_busy)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        tick(2);
        a_rst_n = 1'b1; b_rst_n = 1'b1; c_rst_n = 1'b1;
        tick(1);
        checks++; if (a_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got %0b exp 0", a_vld); end
        checks++; if (a_idx !== 4'hF) begin errors++; $display("FAIL reset_idx got %h exp f", a_idx); end
        checks++; if (a_oh !== 16'h0000) begin errors++; $display("FAIL reset_onehot got %h exp 0000", a_oh); end
        checks++; if (a_busy !== 16'h0000) begin errors++; $display("FAIL reset_busy got %h exp 0000", a_busy); end
        checks++; if (c_idx !== 4'hF) begin errors++; $display("FAIL reset_idx_n12 got %h exp f", c_idx); end
    endtask

    task automatic test_fixed_grant;
        a_req = 16'h0120; a_en_n = 1'b0;
        tick(1);
        checks++; if (a_vld !== 1'b1) begin errors++; $display("FAIL fixed_vld got %0b exp 1", a_vld); end
        checks++; if (a_idx !== 4'd5) begin errors++; $display("FAIL fixed_idx got %0d exp 5", a_idx); end
        checks++; if (a_oh !== 16'h0020) begin errors++; $display("FAIL fixed_onehot got %h exp 0020", a_oh); end
        checks++; if (a_busy !== 16'd0) begin errors++; $display("FAIL fixed_busy got %0d exp 0", a_busy); end
    endtask

    task automatic test_lock;
        a_req = 16'h0001; a_en_n = 1'b1;
        tick(10);
        checks++; if (a_vld !== 1'b1) begin errors++; $display("FAIL lock_vld got %0b exp 1", a_vld); end
        checks++; if (a_idx !== 4'd5) begin errors++; $display("FAIL lock_idx got %0d exp 5", a_idx); end
        checks++; if (a_busy !== 16'd10) begin errors++; $display("FAIL lock_busy got %0d exp 10", a_busy); end
        a_rel = 1'b1;
        tick(1);
        a_rel = 1'b0;
        checks++; if (a_vld !== 1'b0) begin errors++; $display("FAIL lock_drop_vld got %0b exp 0", a_vld); end
        checks++; if (a_idx !== 4'hF) begin errors++; $display("FAIL lock_drop_idx got %h exp f", a_idx); end
        checks++; if (a_oh !== 16'h0000) begin errors++; $display("FAIL lock_drop_onehot got %h exp 0000", a_oh); end
        checks++; if (a_busy !== 16'd10) begin errors++; $display("FAIL lock_drop_busy got %0d exp 10", a_busy); end
        // release while idle has no effect
        a_rel = 1'b1;
        tick(1);
        a_rel = 1'b0;
        checks++; if (a_vld !== 1'b0) begin errors++; $display("FAIL idle_release_vld got %0b exp 0", a_vld); end
    endtask

    task automatic test_fixed_back_to_back;
        a_req = 16'h0120; a_en_n = 1'b0;
        tick(3);
        checks++; if (a_idx !== 4'd5) begin errors++; $display("FAIL b2b_first_idx got %0d exp 5", a_idx); end
        checks++; if (a_busy !== 16'd2) begin errors++; $display("FAIL b2b_busy_cleared got %0d exp 2", a_busy); end
        // owner still requesting wins again at once in fixed mode
        a_rel = 1'b1;
        tick(1);
        checks++; if (a_vld !== 1'b1) begin errors++; $display("FAIL b2b_rewin_vld got %0b exp 1", a_vld); end
        checks++; if (a_idx !== 4'd5) begin errors++; $display("FAIL b2b_rewin_idx got %0d exp 5", a_idx); end
        checks++; if (a_busy !== 16'd0) begin errors++; $display("FAIL b2b_rewin_busy got %0d exp 0", a_busy); end
        a_req = 16'h0100;
        tick(1);
        a_rel = 1'b0;
        checks++; if (a_idx !== 4'd8) begin errors++; $display("FAIL b2b_next_idx got %0d exp 8", a_idx); end
        checks++; if (a_oh !== 16'h0100) begin errors++; $display("FAIL b2b_next_onehot got %h exp 0100", a_oh); end
    endtask

    task automatic test_rr_back_to_back;
        logic [3:0] exp_seq [4];
        exp_seq[0] = 4'd5; exp_seq[1] = 4'd10; exp_seq[2] = 4'd15; exp_seq[3] = 4'd0;
        b_req = 16'h8421; b_en_n = 1'b0;
        tick(1);
        checks++; if (b_idx !== 4'd0) begin errors++; $display("FAIL rr_first_idx got %0d exp 0", b_idx); end
        b_rel = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick(1);
            checks++; if (b_vld !== 1'b1) begin errors++; $display("FAIL rr_seq_vld step %0d got %0b exp 1", k, b_vld); end
            checks++; if (b_idx !== exp_seq[k]) begin errors++; $display("FAIL rr_seq_idx step %0d got %0d exp %0d", k, b_idx, exp_seq[k]); end
        end
        // one more release leaves the pointer at 1 with owner 5
        tick(1);
        b_rel = 1'b0;
        checks++; if (b_idx !== 4'd5) begin errors++; $display("FAIL rr_after_wrap_idx got %0d exp 5", b_idx); end
    endtask

    task automatic test_async_reset;
        tick(1);
        #2;
        b_rst_n = 1'b0;
        #1;
        checks++; if (b_vld !== 1'b0) begin errors++; $display("FAIL areset_vld got %0b exp 0", b_vld); end
        checks++; if (b_idx !== 4'hF) begin errors++; $display("FAIL areset_idx got %h exp f", b_idx); end
        checks++; if (b_oh !== 16'h0000) begin errors++; $display("FAIL areset_onehot got %h exp 0000", b_oh); end
        checks++; if (b_busy !== 16'h0000) begin errors++; $display("FAIL areset_busy got %h exp 0000", b_busy); end
        #1;
        b_rst_n = 1'b1;
        tick(1);
        // pointer back at 0: lowest requester 0 wins rather than 5
        checks++; if (b_idx !== 4'd0) begin errors++; $display("FAIL areset_regrant_idx got %0d exp 0", b_idx); end
        checks++; if (b_vld !== 1'b1) begin errors++; $display("FAIL areset_regrant_vld got %0b exp 1", b_vld); end
    endtask

    task automatic test_rr_wrap_n12;
        c_req = 12'h800; c_en_n = 1'b0;
        tick(1);
        checks++; if (c_idx !== 4'd11) begin errors++; $display("FAIL wrap_owner_idx got %0d exp 11", c_idx); end
        c_req = 12'h801; c_rel = 1'b1;
        tick(1);
        checks++; if (c_vld !== 1'b1) begin errors++; $display("FAIL wrap_vld got %0b exp 1", c_vld); end
        checks++; if (c_idx !== 4'd0) begin errors++; $display("FAIL wrap_idx got %0d exp 0", c_idx); end
        checks++; if (c_oh !== 12'h001) begin errors++; $display("FAIL wrap_onehot got %h exp 001", c_oh); end
        tick(1);
        c_rel = 1'b0;
        checks++; if (c_idx !== 4'd11) begin errors++; $display("FAIL wrap_next_idx got %0d exp 11", c_idx); end
    endtask

    task automatic test_saturation;
        // instance A holds owner 8 with release low
        tick(70000);
        checks++; if (a_busy !== 16'hFFFF) begin errors++; $display("FAIL sat_busy got %h exp ffff", a_busy); end
        checks++; if (a_idx !== 4'd8) begin errors++; $display("FAIL sat_idx got %0d exp 8", a_idx); end
        a_req = 16'h0000; a_rel = 1'b1;
        tick(1);
        a_rel = 1'b0;
        checks++; if (a_vld !== 1'b0) begin errors++; $display("FAIL sat_drop_vld got %0b exp 0", a_vld); end
        tick(3);
        checks++; if (a_busy !== 16'hFFFF) begin errors++; $display("FAIL sat_hold_busy got %h exp ffff", a_busy); end
        a_req = 16'h0002;
        tick(1);
        checks++; if (a_busy !== 16'h0000) begin errors++; $display("FAIL sat_newgrant_busy got %h exp 0000", a_busy); end
        checks++; if (a_idx !== 4'd1) begin errors++; $display("FAIL sat_newgrant_idx got %0d exp 1", a_idx); end
    endtask

    initial begin
        test_reset();
        test_fixed_grant();
        test_lock();
        test_fixed_back_to_back();
        test_rr_back_to_back();
        test_async_reset();
        test_rr_wrap_n12();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
